// File: rtl/pid_pwm_out.sv
// pid_pwm_out: output stage of the servo position loop.
// Converts the signed controller output into a direction bit plus a saturated
// duty magnitude, and drives a fixed-period PWM whose duty/direction change
// only at period boundaries. Period_Tick doubles as the controller sample strobe.
module pid_pwm_out #(
  parameter int cant_bits = 13,
  parameter int SHIFT     = 4,
  parameter int DW        = 12,
  parameter int PER       = 2500,
  parameter int PWM_MAX   = 2375
) (
  input  logic                          Clk_G,
  input  logic                          Rst_G,
  input  logic signed [2*cant_bits-1:0] U_In,
  input  logic                          U_Valid,
  output logic                          Busy,
  output logic                          PWM,
  output logic                          Dir,
  output logic                          Sat,
  output logic                          Period_Tick
);

  localparam int UW = 2 * cant_bits;
  localparam logic [DW-1:0] CNT_LAST  = DW'(PER - 1);
  localparam logic [DW-1:0] DUTY_MAX  = DW'(PWM_MAX);
  localparam logic [UW-1:0] MAG_LIMIT = UW'(PWM_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    CLAMP = 2'd2
  } state_t;

  state_t        state;
  logic [DW-1:0] cnt;
  logic [DW-1:0] duty_act;
  logic [DW-1:0] duty_shd;
  logic          dir_shd;
  logic          pending;
  logic [UW-1:0] u_r;
  logic          dir_r;
  logic [UW-1:0] mag_r;
  logic [UW-1:0] u_abs;

  // Magnitude of the captured sample as an unsigned value; the most negative
  // input maps to 2**(UW-1), which still fits in UW unsigned bits.
  always_comb begin
    u_abs = u_r[UW-1] ? (~u_r + UW'(1)) : u_r;
  end

  // PWM is decoded from registers only, so it cannot glitch within a period.
  always_comb begin
    PWM  = (cnt < duty_act);
    Busy = (state != IDLE);
  end

  // Period counter, boundary-synchronous duty/direction update and the
  // conversion FSM. They share one block because pending is set by the FSM
  // and cleared by the wrap; a CLAMP write on the wrap edge must win so the
  // freshly stored shadow is applied at the following wrap.
  always_ff @(posedge Clk_G or posedge Rst_G) begin
    if (Rst_G) begin
      cnt         <= '0;
      duty_act    <= '0;
      duty_shd    <= '0;
      dir_shd     <= 1'b0;
      pending     <= 1'b0;
      Dir         <= 1'b0;
      Sat         <= 1'b0;
      Period_Tick <= 1'b0;
      state       <= IDLE;
      u_r         <= '0;
      dir_r       <= 1'b0;
      mag_r       <= '0;
    end else begin
      Period_Tick <= (cnt == CNT_LAST);

      if (cnt == CNT_LAST) begin
        cnt <= '0;
        // Only a completed conversion is ever applied, and only here.
        if (pending) begin
          duty_act <= duty_shd;
          Dir      <= dir_shd;
          pending  <= 1'b0;
        end
      end else begin
        cnt <= cnt + DW'(1);
      end

      case (state)
        IDLE: begin
          if (U_Valid) begin
            u_r   <= $unsigned(U_In);
            state <= SCALE;
          end
        end
        SCALE: begin
          dir_r <= u_r[UW-1];
          mag_r <= u_abs >> SHIFT;
          state <= CLAMP;
        end
        CLAMP: begin
          if (mag_r > MAG_LIMIT) begin
            duty_shd <= DUTY_MAX;
            Sat      <= 1'b1;
          end else begin
            duty_shd <= mag_r[DW-1:0];
            Sat      <= 1'b0;
          end
          dir_shd <= dir_r;
          pending <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pid_pwm_out.sv
// tb_pid_pwm_out: directed plus randomized bench for pid_pwm_out. Each PWM
// period is measured cycle by cycle and compared to a period-level model of
// which duty/direction must be active, derived from the conversion rule
// duty = min(|U| >> 4, 2375).
module tb_pid_pwm_out;

  localparam int UW      = 26;
  localparam int PER     = 2500;
  localparam int PWM_MAX = 2375;

  logic                 clk;
  logic                 rst;
  logic signed [UW-1:0] u_in;
  logic                 u_valid;
  logic                 busy;
  logic                 pwm;
  logic                 dir;
  logic                 sat;
  logic                 tick;

  int errors = 0;
  int checks = 0;

  // Model: duty/direction of the running period, the update due at the next
  // wrap, and one that missed this wrap (CLAMP on the wrap edge).
  int exp_duty = 0;
  bit exp_dir  = 0;
  bit exp_sat  = 0;
  bit pend_v   = 0;
  int pend_duty;
  bit pend_dir;
  bit late_v   = 0;
  int late_duty;
  bit late_dir;

  pid_pwm_out dut (
    .Clk_G      (clk),
    .Rst_G      (rst),
    .U_In       (u_in),
    .U_Valid    (u_valid),
    .Busy       (busy),
    .PWM        (pwm),
    .Dir        (dir),
    .Sat        (sat),
    .Period_Tick(tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic void conv(input longint u, output int duty, output bit d, output bit s);
    longint mag;
    mag  = ((u < 0) ? -u : u) / 16;
    s    = (mag > PWM_MAX);
    duty = s ? PWM_MAX : int'(mag);
    d    = (u < 0);
  endfunction

  // Record a conversion sampled at period offset o.
  task automatic model_send(input int o, input longint u);
    int du;
    bit d;
    bit s;
    conv(u, du, d, s);
    exp_sat = s;
    if (o <= PER - 4) begin
      pend_v = 1; pend_duty = du; pend_dir = d;
    end else begin
      late_v = 1; late_duty = du; late_dir = d;
    end
  endtask

  task automatic model_wrap();
    if (pend_v) begin
      exp_duty = pend_duty;
      exp_dir  = pend_dir;
    end
    pend_v    = late_v;
    pend_duty = late_duty;
    pend_dir  = late_dir;
    late_v    = 0;
  endtask

  task automatic model_reset();
    exp_duty = 0; exp_dir = 0; exp_sat = 0; pend_v = 0; late_v = 0;
  endtask

  // Wait (bounded) for Period_Tick and check the distance in cycles.
  task automatic wait_tick(input string tag);
    int n = 0;
    while (!tick && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, n, PER);
  endtask

  // Measure one period starting at the tick cycle (cnt==0). Optionally injects
  // a conversion at off1 (with a second, ignored U_Valid right after when dbl)
  // and another at off2. Ends at the next tick cycle.
  task automatic measure(input string tag, input int off1, input longint u1,
                         input bit dbl, input int off2, input longint u2);
    int hi = 0;
    int bad = 0;
    $display("%s: off1=%0d u1=%0d dbl=%0d off2=%0d u2=%0d exp_duty=%0d exp_dir=%0d",
             tag, off1, u1, dbl, off2, u2, exp_duty, exp_dir);
    for (int i = 0; i < PER; i++) begin
      if (i == 0) begin
        check({tag, " tick"}, tick, 1);
        check({tag, " dir_start"}, dir, exp_dir);
        check({tag, " sat"}, sat, exp_sat);
      end
      if (i == 1) check({tag, " tick_low"}, tick, 0);
      if (i == PER - 1) check({tag, " dir_end"}, dir, exp_dir);
      if (off1 >= 0 && i == off1 + 1) check({tag, " busy"}, busy, 1);
      if (off1 >= 0 && i == off1 + 3) check({tag, " idle"}, busy, 0);
      if (pwm) hi++;
      if (pwm !== (i < exp_duty)) bad++;
      if (off1 >= 0 && i == off1) begin
        u_valid = 1; u_in = UW'(u1); model_send(i, u1);
      end else if (dbl && off1 >= 0 && i == off1 + 1) begin
        u_valid = 1; u_in = UW'(48);
      end else if (off2 >= 0 && i == off2) begin
        u_valid = 1; u_in = UW'(u2); model_send(i, u2);
      end else begin
        u_valid = 0;
      end
      @(negedge clk);
    end
    u_valid = 0;
    check({tag, " high"}, hi, exp_duty);
    check({tag, " shape"}, bad, 0);
    model_wrap();
  endtask

  initial begin
    longint ur;
    int     off;
    rst = 1; u_valid = 0; u_in = '0;
    repeat (3) @(negedge clk);
    $display("reset: pwm=%0d dir=%0d sat=%0d tick=%0d busy=%0d", pwm, dir, sat, tick, busy);
    check("rst pwm", pwm, 0);
    check("rst dir", dir, 0);
    check("rst sat", sat, 0);
    check("rst tick", tick, 0);
    check("rst busy", busy, 0);
    rst = 0;
    wait_tick("first tick");

    measure("idle",      -1, 0, 0, -1, 0);
    measure("p+1600",    300, 1600, 0, -1, 0);
    measure("p-800",     10, -800, 0, -1, 0);
    measure("p+100000",  700, 100000, 0, -1, 0);
    measure("p-2^25dbl", 50, -(64'sd1 <<< 25), 1, -1, 0);
    measure("p+1600b",   20, 1600, 0, -1, 0);
    measure("p+3200mid", 500, 3200, 0, -1, 0);
    measure("p_two",     100, 800, 0, 900, -1600);
    measure("p_coinc",   PER - 3, 0, 0, -1, 0);
    measure("p_old",     -1, 0, 0, -1, 0);
    measure("p_zero",    -1, 0, 0, -1, 0);

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) ur = longint'($urandom_range(0, 80000)) - 40000;
      else            ur = longint'($urandom_range(0, (1 << 26) - 1)) - (64'sd1 <<< 25);
      off = int'($urandom_range(0, PER - 3));
      measure("rand", off, ur, 0, -1, 0);
    end

    measure("pre_rst", 10, 30000, 0, -1, 0);
    // Reset mid-period with a conversion outstanding.
    $display("mid-period reset: exp_duty=%0d", exp_duty);
    for (int i = 0; i < 1200; i++) begin
      u_valid = (i == 100);
      u_in    = UW'(-40000);
      @(negedge clk);
    end
    u_valid = 0;
    check("pre_rst pwm", pwm, 1);
    rst = 1;
    #1;
    check("mid_rst pwm", pwm, 0);
    check("mid_rst dir", dir, 0);
    check("mid_rst busy", busy, 0);
    @(negedge clk);
    rst = 0;
    model_reset();
    wait_tick("tick after rst");
    measure("post_rst", -1, 0, 0, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
